// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N decoder with active-low enable, one-cold
// active-low outputs and an autonomous scan mode that steps the decoded index
// every PRESCALE clocks (digit strobes, row selects).
//
// Optional feature macro: DEC_SCAN_BLANK_EN
//   defined   -> the last cycle of every scan step is blanked (Y_L all ones)
//                to suppress ghosting between adjacent strobes; needs
//                PRESCALE >= 2.
//   undefined -> Y_L switches directly from one index to the next.
module dec_scan_n #(
   parameter int SEL_W    = 2,
   parameter int PRESCALE = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_g_l,
   input  logic                    i_mode,
   input  logic [SEL_W-1:0]        i_sel,
   output logic [(2**SEL_W)-1:0]   o_y_l,
   output logic [SEL_W-1:0]        o_idx,
   output logic                    o_step
);

   localparam int OUT_N = 2**SEL_W;
   // Prescale counter must hold 0..PRESCALE-1; keep at least one bit.
   localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRESCALE - 1);
`ifdef DEC_SCAN_BLANK_EN
   localparam logic [PC_W-1:0] PC_BLANK = PC_W'(PRESCALE - 2);
`endif

   // OFF: outputs blanked, scan position frozen.
   // DIRECT: SEL decoded straight through.
   // SCAN: free-running index stepping.
   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t            r_state;
   logic [SEL_W-1:0]  r_idx;
   logic [PC_W-1:0]   r_pc;
   logic [OUT_N-1:0]  r_y_l;
   logic              r_step;

   state_t            w_state_nxt;
   logic [SEL_W-1:0]  w_idx_nxt;
   logic [SEL_W-1:0]  w_idx_inc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [OUT_N-1:0]  w_y_l_nxt;
   logic              w_step_nxt;

   // Active-low one-cold pattern for an index: exactly one bit low.
   function automatic logic [OUT_N-1:0] f_dec_l(input logic [SEL_W-1:0] idx);
      logic [OUT_N-1:0] one_hot;
      one_hot      = '0;
      one_hot[idx] = 1'b1;
      return ~one_hot;
   endfunction

   // Next state and next register values from sampled G_L/MODE and current state.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      w_state_nxt = ST_OFF;
      w_idx_nxt   = r_idx;
      w_pc_nxt    = r_pc;
      w_y_l_nxt   = '1;
      w_step_nxt  = 1'b0;
      // Index wraps naturally because OUT_N is a power of two.
      w_idx_inc   = r_idx + 1'b1;

      if (i_g_l) begin
         // Disabled: blank outputs, hold IDX and PC so the scan can resume.
         w_state_nxt = ST_OFF;
      end else if (!i_mode) begin
         w_state_nxt = ST_DIRECT;
         w_idx_nxt   = i_sel;
         w_pc_nxt    = '0;
         w_y_l_nxt   = f_dec_l(i_sel);
      end else if (r_state == ST_DIRECT) begin
         // Scan entry from direct decode starts a fresh step at SEL.
         w_state_nxt = ST_SCAN;
         w_idx_nxt   = i_sel;
         w_pc_nxt    = '0;
         w_y_l_nxt   = f_dec_l(i_sel);
      end else begin
         // Running scan, or resuming from OFF: counting continues on this edge.
         w_state_nxt = ST_SCAN;
         if (r_pc == PC_LAST) begin
            w_pc_nxt   = '0;
            w_idx_nxt  = w_idx_inc;
            w_y_l_nxt  = f_dec_l(w_idx_inc);
            w_step_nxt = 1'b1;
         end else begin
            w_pc_nxt   = r_pc + 1'b1;
`ifdef DEC_SCAN_BLANK_EN
            if (r_pc == PC_BLANK) begin
               w_y_l_nxt = '1;
            end else begin
               w_y_l_nxt = f_dec_l(r_idx);
            end
`else
            w_y_l_nxt  = f_dec_l(r_idx);
`endif
         end
      end
   end

   // State and output registers; synchronous reset wins over every other input.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (i_reset) begin
         r_state <= ST_OFF;
         r_idx   <= '0;
         r_pc    <= '0;
         r_y_l   <= '1;
         r_step  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_pc    <= w_pc_nxt;
         r_y_l   <= w_y_l_nxt;
         r_step  <= w_step_nxt;
      end
   end

   assign o_y_l  = r_y_l;
   assign o_idx  = r_idx;
   assign o_step = r_step;

endmodule

// File: tb/tb_dec_scan_n.sv
// Testbench for dec_scan_n (SEL_W=2, PRESCALE=4): table-driven direct/off/reset
// vectors, hand-written scan sequences, then randomized stimulus checked
// against a phase-based reference model.
module tb_dec_scan_n;

   localparam int SEL_W    = 2;
   localparam int PRESCALE = 4;
   localparam int OUT_N    = 4;
   localparam int PERIOD   = OUT_N * PRESCALE;
`ifdef DEC_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       g_l;
   logic       mode;
   logic [1:0] sel;
   logic [3:0] y_l;
   logic [1:0] idx;
   logic       step;

   int n_checks = 0;
   int n_errors = 0;

   dec_scan_n #(.SEL_W(SEL_W), .PRESCALE(PRESCALE)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_g_l   (g_l),
      .i_mode  (mode),
      .i_sel   (sel),
      .o_y_l   (y_l),
      .o_idx   (idx),
      .o_step  (step)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       g_l;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] y;
      logic [1:0] idx;
      logic       step;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic g, input logic m, input logic [1:0] s);
      rst  = r;
      g_l  = g;
      mode = m;
      sel  = s;
   endtask

   function automatic logic [3:0] dec(input int i);
      logic [3:0] one;
      one = 4'(1) << i;
      return ~one;
   endfunction

   // Reference model: scan position as a single phase 0..PERIOD-1;
   // index = phase / PRESCALE, position within step = phase % PRESCALE.
   int         m_state;  // 0 off, 1 direct, 2 scan
   int         m_phase;
   int         m_idx;
   logic       m_step;
   logic [3:0] m_y;

   task automatic model_step(input logic r, input logic g, input logic m, input logic [1:0] s);
      if (r) begin
         m_state = 0; m_phase = 0; m_step = 1'b0; m_y = 4'hF;
      end else if (g) begin
         m_state = 0; m_step = 1'b0; m_y = 4'hF;
      end else if (!m || m_state == 1) begin
         m_phase = int'(s) * PRESCALE;
         m_state = m ? 2 : 1;
         m_step  = 1'b0;
         m_y     = dec(int'(s));
      end else begin
         m_phase = (m_phase + 1) % PERIOD;
         m_state = 2;
         m_step  = (m_phase % PRESCALE == 0);
         m_y     = (BLANK && (m_phase % PRESCALE == PRESCALE - 1)) ? 4'hF : dec(m_phase / PRESCALE);
      end
      m_idx = m_phase / PRESCALE;
   endtask

   initial begin
      logic       r_g, r_m, r_r;
      logic [1:0] r_s;
      int         e_idx;
      logic       e_step;
      logic [3:0] e_y;

      drive(1'b1, 1'b1, 1'b0, 2'd0);

      //          rst   g_l   mode  sel    y      idx    step
      vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 2'd0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'hE, 2'd0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd1, 4'hD, 2'd1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd2, 4'hB, 2'd2, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd3, 4'h7, 2'd3, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 2'd3, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 4'hF, 2'd3, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 2'd1, 4'hD, 2'd1, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 2'd0, 1'b0};

      tick();
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].rst, vecs[i].g_l, vecs[i].mode, vecs[i].sel);
         tick();
         check($sformatf("vec%0d y_l", i),  32'(y_l),  32'(vecs[i].y));
         check($sformatf("vec%0d idx", i),  32'(idx),  32'(vecs[i].idx));
         check($sformatf("vec%0d step", i), 32'(step), 32'(vecs[i].step));
      end

      // Scan entry from direct at SEL=2; SEL is scrambled afterwards and must be ignored.
      drive(1'b0, 1'b0, 1'b0, 2'd2);
      tick();
      drive(1'b0, 1'b0, 1'b1, 2'd2);
      tick();
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            drive(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
            tick();
         end
         e_idx  = (2 + c / 4) % 4;
         e_step = (c > 0 && c % 4 == 0);
         e_y    = (BLANK && c % 4 == 3) ? 4'hF : dec(e_idx);
         check($sformatf("scan c%0d idx", c),  32'(idx),  32'(e_idx));
         check($sformatf("scan c%0d step", c), 32'(step), 32'(e_step));
         check($sformatf("scan c%0d y_l", c),  32'(y_l),  32'(e_y));
      end

      // Pause at IDX=3, PC=1 for 5 cycles, then resume.
      drive(1'b0, 1'b0, 1'b0, 2'd3);
      tick();
      drive(1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      drive(1'b0, 1'b0, 1'b1, 2'd0);
      tick();
      check("pause pre idx", 32'(idx), 32'd3);
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
         tick();
         check($sformatf("pause c%0d y_l", c),  32'(y_l),  32'hF);
         check($sformatf("pause c%0d idx", c),  32'(idx),  32'd3);
         check($sformatf("pause c%0d step", c), 32'(step), 32'd0);
      end
      drive(1'b0, 1'b0, 1'b1, 2'd1);
      tick();
      check("resume0 y_l", 32'(y_l), 32'h7);
      check("resume0 idx", 32'(idx), 32'd3);
      tick();
      check("resume1 y_l", 32'(y_l), BLANK ? 32'hF : 32'h7);
      check("resume1 idx", 32'(idx), 32'd3);
      tick();
      check("resume2 idx",  32'(idx),  32'd0);
      check("resume2 step", 32'(step), 32'd1);
      check("resume2 y_l",  32'(y_l),  32'hE);

      // Reset mid-scan at IDX=2, PC=2; restart must take a full step at IDX 0.
      drive(1'b0, 1'b0, 1'b0, 2'd2);
      tick();
      drive(1'b0, 1'b0, 1'b1, 2'd2);
      tick();
      tick();
      tick();
      check("pre-reset idx", 32'(idx), 32'd2);
      drive(1'b1, 1'b0, 1'b1, 2'd3);
      tick();
      check("midrst y_l",  32'(y_l),  32'hF);
      check("midrst idx",  32'(idx),  32'd0);
      check("midrst step", 32'(step), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 2'd3);
      for (int c = 1; c <= 4; c++) begin
         tick();
         e_idx  = (c == 4) ? 1 : 0;
         e_step = (c == 4);
         e_y    = (BLANK && c == 3) ? 4'hF : dec(e_idx);
         check($sformatf("postrst c%0d idx", c),  32'(idx),  32'(e_idx));
         check($sformatf("postrst c%0d step", c), 32'(step), 32'(e_step));
         check($sformatf("postrst c%0d y_l", c),  32'(y_l),  32'(e_y));
      end

      // Randomized run against the reference model, starting from reset.
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      model_step(1'b1, 1'b0, 1'b0, 2'd0);
      tick();
      r_g = 1'b0;
      r_m = 1'b1;
      for (int n = 0; n < 600; n++) begin
         r_r = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 11) == 0) r_g = ~r_g;
         if ($urandom_range(0, 15) == 0) r_m = ~r_m;
         r_s = 2'($urandom_range(0, 3));
         drive(r_r, r_g, r_m, r_s);
         model_step(r_r, r_g, r_m, r_s);
         tick();
         check($sformatf("rand%0d y_l", n),  32'(y_l),  32'(m_y));
         check($sformatf("rand%0d idx", n),  32'(idx),  32'(m_idx));
         check($sformatf("rand%0d step", n), 32'(step), 32'(m_step));
         check($sformatf("rand%0d onecold", n), 32'($countones(~y_l) <= 1), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dec_scan_n.md
# dec_scan_n

Parametrised, registered N-to-2^N decoder with active-low enable and active-low one-cold outputs, generalising the dual 2-to-4 decoder family. Besides direct decoding of a select input, it has an autonomous scan mode: an internal index counter steps through all outputs at a programmable rate, for multiplexed display digit strobes and row-select drivers. It sits between control logic and the output pins it strobes.

## Interface
- SEL_W, 2, select width; output count OUT_N = 2**SEL_W (SEL_W 1..5)
- PRESCALE, 4, clock cycles per scan step (>=1; >=2 when blanking compiled in)
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- G_L  in  1  enable, active-low; high forces all outputs inactive
- MODE  in  1  0 = direct decode of SEL, 1 = scan
- SEL  in  SEL_W  select index (direct mode; start index on scan entry)
- Y_L  out  OUT_N  registered one-cold outputs, active-low
- IDX  out  SEL_W  registered index currently decoded/scanned
- STEP  out  1  one-cycle pulse when scan advances to a new index

## Operation
- One clock; reset is synchronous and active-high.
- States: OFF (G_L=1), DIRECT (G_L=0, MODE=0), SCAN (G_L=0, MODE=1). Next state chosen each edge from sampled G_L, MODE.
- Reset: state OFF, Y_L all ones, IDX 0, prescale count PC 0, STEP 0.
- OFF: Y_L <= all ones, STEP <= 0; IDX and PC hold (scan pauses).
- DIRECT: IDX <= SEL, Y_L <= ~(1<<SEL), PC <= 0, STEP <= 0.
- Entry to SCAN from DIRECT: IDX <= SEL, PC <= 0, Y_L <= ~(1<<SEL), STEP <= 0.
- Entry to SCAN from OFF: resume from held IDX and PC; Y_L <= ~(1<<IDX).
- In SCAN: if PC == PRESCALE-1: PC <= 0, IDX <= IDX+1 (wraps OUT_N-1 -> 0), Y_L <= ~(1<<(IDX+1)), STEP <= 1. Else PC <= PC+1, Y_L <= ~(1<<IDX), STEP <= 0.
- PRESCALE=1: IDX advances every cycle, STEP held high.
- SEL ignored in SCAN except on entry; SEL changes in DIRECT take effect next edge.
- Y_L never has more than one bit low.

## Timing
- All outputs registered; input-to-Y_L latency exactly 1 cycle.
- G_L rising: Y_L all ones after next edge; G_L falling in SCAN resumes counting on the same edge that re-drives Y_L.
- RESET has priority over G_L/MODE on the same edge; RESET mid-scan returns IDX 0, PC 0 at next edge; first scan step after reset-release is full PRESCALE cycles.
- STEP coincides with the cycle Y_L first shows the new index.
- Scan period: OUT_N*PRESCALE cycles.

## Configuration
- DEC_SCAN_BLANK_EN defined: anti-ghosting blank. In SCAN, on the edge where PC == PRESCALE-2, Y_L <= all ones; each index is visible PRESCALE-1 cycles followed by 1 blank cycle; IDX/STEP timing unchanged. PRESCALE < 2 is a configuration error.
- Not defined: no blank cycle; Y_L switches directly between adjacent indices.

## Test plan
- Reset: RESET=1 one edge with G_L=0, MODE=1 -> Y_L=4'b1111, IDX=0, STEP=0 (SEL_W=2).
- Direct: G_L=0, MODE=0, SEL=0,1,2,3 each 1 cycle -> Y_L 1110,1101,1011,0111 one cycle later; G_L=1 -> 1111 next cycle.
- Scan: SEL=2, MODE 0->1, PRESCALE=4 -> IDX 2 for 4 cycles, then 3, 0 (wrap), 1; STEP high exactly on cycles 4, 8, 12 after entry.
- Pause/resume: in SCAN at PC=1, IDX=3, raise G_L 5 cycles -> Y_L=1111, IDX stays 3; lower G_L -> Y_L=0111, advance to 0 after 2 more cycles.
- Blank (DEC_SCAN_BLANK_EN, PRESCALE=4): each index low 3 cycles then Y_L=1111 one cycle; STEP aligned with next index.
- Reset mid-scan at IDX=2, PC=2 -> IDX=0, PC=0, Y_L=1111 next edge; after release with G_L=0, MODE=1, scan starts at IDX 0.
